pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, an optional 2-entry skid buffer, flush and kill. Replaces the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM) of the RISC-V core. Payload splits into two fields:
- a clearable field, replaced by a NOP pattern on bubbles;
- a keep field (e.g. instruction address), which survives bubbles for trap handling.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_stage_reg.sv | 172 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers.
// Holds the skid FSM encoding, the NOP instruction and ID/EX payload slice widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // ID/EX clearable payload: {ctrl, rs2, rs1, inst}
    localparam int IDEX_INST_W = 32;
    localparam int IDEX_RS1_W  = 32;
    localparam int IDEX_RS2_W  = 32;
    localparam int IDEX_CTRL_W = 32;
    localparam int IDEX_DATA_W = IDEX_INST_W + IDEX_RS1_W
                               + IDEX_RS2_W + IDEX_CTRL_W;
    localparam int IDEX_KEEP_W = 32;
    localparam int IDEX_INST_LSB = 0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid,
// flush and kill. The clearable field becomes NOP_DATA on bubbles; the keep
// field (e.g. the PC) survives bubbles.
// Ports: clk, rst (async, active high), flush,
//   in_valid/in_ready/in_data/in_keep/in_kill (upstream),
//   out_valid/out_ready/out_data/out_keep/out_killed (downstream),
//   occupancy (beats held).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W   = 128,
    parameter int                 KEEP_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_DATA = '0,
    parameter bit                 SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_kill,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_killed,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              valid;
        logic              killed;
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        valid:  1'b0,
        killed: 1'b0,
        data:   NOP_DATA,
        keep:   '0
    };

    // Empty an entry but leave its keep field for trap handling.
    function automatic entry_t vacate(input entry_t e);
        entry_t r;
        r        = e;
        r.valid  = 1'b0;
        r.killed = 1'b0;
        r.data   = NOP_DATA;
        return r;
    endfunction

    entry_t main_q;
    entry_t main_d;
    entry_t beat;
    logic   accept;
    logic   rel;

    // A killed beat still flows as a bubble carrying its keep field.
    always_comb begin
        beat.valid  = 1'b1;
        beat.killed = in_kill;
        beat.data   = in_kill ? NOP_DATA : in_data;
        beat.keep   = in_keep;
    end

    assign accept = in_valid && in_ready;
    assign rel    = main_q.valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= RESET_ENTRY;
        end else begin
            main_q <= main_d;
        end
    end

    assign out_valid  = main_q.valid;
    assign out_killed = main_q.killed;
    assign out_data   = main_q.data;
    assign out_keep   = main_q.keep;

    generate
        if (SKID) begin : g_skid
            entry_t      skid_q;
            entry_t      skid_d;
            skid_state_e state_q;
            skid_state_e state_d;
            logic        in_ready_q;
            logic        in_ready_d;

            always_comb begin
                main_d  = main_q;
                skid_d  = skid_q;
                state_d = state_q;
                if (flush) begin
                    main_d  = vacate(main_q);
                    skid_d  = vacate(skid_q);
                    state_d = EMPTY;
                end else begin
                    unique case (state_q)
                        EMPTY: begin
                            if (accept) begin
                                main_d  = beat;
                                state_d = ONE;
                            end
                        end
                        ONE: begin
                            if (accept && rel) begin
                                main_d = beat;
                            end else if (accept) begin
                                skid_d  = beat;
                                state_d = TWO;
                            end else if (rel) begin
                                main_d  = vacate(main_q);
                                state_d = EMPTY;
                            end
                        end
                        TWO: begin
                            if (rel) begin
                                main_d  = skid_q;
                                skid_d  = vacate(skid_q);
                                state_d = ONE;
                            end
                        end
                        default: begin
                            main_d  = vacate(main_q);
                            skid_d  = vacate(skid_q);
                            state_d = EMPTY;
                        end
                    endcase
                end
                // Registered from the next state so TWO never sees an accept.
                in_ready_d = (state_d != TWO);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    skid_q     <= RESET_ENTRY;
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    skid_q     <= skid_d;
                    state_q    <= state_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready  = in_ready_q;
            assign occupancy = {1'b0, main_q.valid}
                             + {1'b0, skid_q.valid};
        end else begin : g_single
            always_comb begin
                main_d = main_q;
                if (flush) begin
                    main_d = vacate(main_q);
                end else if (accept) begin
                    main_d = beat;
                end else if (rel) begin
                    main_d = vacate(main_q);
                end
            end

            assign in_ready  = !main_q.valid || out_ready;
            assign occupancy = {1'b0, main_q.valid};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance checked
// against a queue model of the stage, directed steps then random traffic.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam logic [31:0] NOP0 = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [15:0] in_keep;
    logic        in_kill;
    logic        out_ready;
    logic        sel;

    logic        v1, f1, v0, f0;
    logic        ir1, ov1, okl1, ir0, ov0, okl0;
    logic [31:0] od1, od0;
    logic [15:0] ok1, ok0;
    logic [1:0]  oc1, oc0;

    logic        o_valid, o_ready, o_killed;
    logic [31:0] o_data;
    logic [15:0] o_keep;
    logic [1:0]  o_occ;

    always #5 clk = ~clk;

    assign v1 = in_valid & sel;
    assign f1 = flush & sel;
    assign v0 = in_valid & ~sel;
    assign f0 = flush & ~sel;

    pipe_stage_reg #(
        .DATA_W(32), .KEEP_W(16), .NOP_DATA(INST_NOP), .SKID(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .flush(f1),
        .in_valid(v1), .in_ready(ir1), .in_data(in_data),
        .in_keep(in_keep), .in_kill(in_kill),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_keep(ok1), .out_killed(okl1), .occupancy(oc1)
    );

    pipe_stage_reg #(
        .DATA_W(32), .KEEP_W(16), .NOP_DATA(NOP0), .SKID(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .flush(f0),
        .in_valid(v0), .in_ready(ir0), .in_data(in_data),
        .in_keep(in_keep), .in_kill(in_kill),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_keep(ok0), .out_killed(okl0), .occupancy(oc0)
    );

    assign o_valid  = sel ? ov1  : ov0;
    assign o_ready  = sel ? ir1  : ir0;
    assign o_killed = sel ? okl1 : okl0;
    assign o_data   = sel ? od1  : od0;
    assign o_keep   = sel ? ok1  : ok0;
    assign o_occ    = sel ? oc1  : oc0;

    typedef struct {
        logic [31:0] d;
        logic [15:0] k;
        logic        kl;
    } beat_t;

    beat_t       q[$];
    logic [15:0] hk;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [31:0] nop();
        return sel ? INST_NOP : NOP0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check model vs DUT at negedge, advance model.
    task automatic cycle(input logic v, input logic [31:0] d,
                         input logic [15:0] k, input logic kl,
                         input logic orr, input logic fl,
                         output logic acc);
        logic  ev, erdy, rel;
        beat_t b;
        in_valid  = v;
        in_data   = d;
        in_keep   = k;
        in_kill   = kl;
        out_ready = orr;
        flush     = fl;
        #4;
        ev   = q.size() > 0;
        erdy = sel ? (q.size() < 2) : (!ev || orr);
        chk("out_valid", o_valid, ev);
        chk("out_data", o_data, ev ? q[0].d : nop());
        chk("out_keep", o_keep, ev ? q[0].k : hk);
        chk("out_killed", o_killed, ev ? q[0].kl : 1'b0);
        chk("occupancy", o_occ, q.size());
        chk("in_ready", o_ready, erdy);
        acc = v && erdy;
        rel = ev && orr;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (rel) void'(q.pop_front());
            if (acc) begin
                b.d  = kl ? nop() : d;
                b.k  = k;
                b.kl = kl;
                q.push_back(b);
            end
        end
        if (q.size() > 0) hk = q[0].k;
    endtask

    task automatic go(input logic v, input logic [31:0] d,
                      input logic [15:0] k, input logic kl,
                      input logic orr, input logic fl);
        logic a;
        cycle(v, d, k, kl, orr, fl, a);
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge.
    task automatic do_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        in_kill  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_data", o_data, nop());
        chk("rst_keep", o_keep, 16'h0);
        chk("rst_occ", o_occ, 2'd0);
        chk("rst_killed", o_killed, 1'b0);
        q.delete();
        hk = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic random_run(input int n);
        logic [31:0] d;
        logic [15:0] k;
        logic        kl, a, pend;
        pend = 1'b0;
        d = '0;
        k = '0;
        kl = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!pend) begin
                d  = $urandom;
                k  = 16'($urandom);
                kl = ($urandom_range(0, 7) == 0);
                pend = ($urandom_range(0, 3) != 0);
            end
            cycle(pend, d, k, kl, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0), a);
            if (a) pend = 1'b0;
        end
    endtask

    initial begin
        int   nxt;
        logic a;
        sel = 1'b1;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_keep = '0;
        in_kill = 1'b0;
        out_ready = 1'b0;
        hk = '0;
        #2;
        chk("por_valid", o_valid, 1'b0);
        chk("por_data", o_data, INST_NOP);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) go(1, i, 16'(i), 0, 1, 0);
        go(0, 0, 0, 0, 1, 0);
        go(0, 0, 0, 0, 1, 0);

        // Backpressure A, B, C
        go(1, 32'hA, 16'hA, 0, 0, 0);
        go(1, 32'hB, 16'hB, 0, 0, 0);
        chk("bp_occ", o_occ, 2'd2);
        chk("bp_ready", o_ready, 1'b0);
        chk("bp_head", o_data, 32'hA);
        go(1, 32'hC, 16'hC, 0, 0, 0);
        go(1, 32'hC, 16'hC, 0, 1, 0);
        go(1, 32'hC, 16'hC, 0, 1, 0);
        go(0, 0, 0, 0, 1, 0);
        go(0, 0, 0, 0, 1, 0);

        // Kill
        go(1, 32'hDEAD, 16'h80, 1, 1, 0);
        chk("kill_valid", o_valid, 1'b1);
        chk("kill_killed", o_killed, 1'b1);
        chk("kill_data", o_data, INST_NOP);
        chk("kill_keep", o_keep, 16'h80);
        go(0, 0, 0, 0, 1, 0);

        // Flush while full with in_valid high
        go(1, 32'h11, 16'h11, 0, 0, 0);
        go(1, 32'h22, 16'h22, 0, 0, 0);
        go(1, 32'h33, 16'h33, 0, 0, 1);
        chk("fl_valid", o_valid, 1'b0);
        chk("fl_occ", o_occ, 2'd0);
        chk("fl_ready", o_ready, 1'b1);
        chk("fl_keep", o_keep, 16'h11);
        // Flush in ONE drops the same-cycle accept
        go(1, 32'h44, 16'h44, 0, 0, 0);
        go(1, 32'h55, 16'h55, 0, 1, 1);
        go(0, 0, 0, 0, 1, 0);
        go(0, 0, 0, 0, 1, 0);

        // Reset while holding two beats
        go(1, 32'h66, 16'h66, 0, 0, 0);
        go(1, 32'h77, 16'h77, 0, 0, 0);
        do_reset();
        go(0, 0, 0, 0, 1, 0);

        random_run(400);

        // Single-register instance
        sel = 1'b0;
        do_reset();
        nxt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 32'(100 + nxt), 16'(nxt), 0, i[0], 0, a);
            if (a) nxt++;
        end
        chk("sk0_rate", nxt, 7);
        go(0, 0, 0, 0, 1, 0);
        go(1, 32'hBEEF, 16'h42, 1, 0, 0);
        go(0, 0, 0, 0, 0, 1);
        chk("sk0_fl_keep", o_keep, 16'h42);
        random_run(400);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
